br_cc_resolver: RTL and testbench

- Pipelined branch resolution unit for the LC-3b datapath.
- Owns the architectural NZP condition-code register and resolves BR instructions against it, including multi-bit nzp masks.
- Carries a parametrised branch history table of saturating counters. The table predicts at fetch, is trained at resolve, and flags mispredicts back to the control FSM.
- Sits between the writeback stage (CC source) and the fetch/control logic.

---
 rtl/lc3b_types.sv | 21 ++
 rtl/sat_counter.sv | 27 ++
 rtl/br_cc_resolver.sv | 101 ++++++++++
 tb/tb_br_cc_resolver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// LC-3b shared types: datapath word, condition codes,
// and the NZP derivation used by both CC register copies.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;

  localparam logic [3:0] op_br = 4'b0000;

  function automatic lc3b_nzp nzp_of(input lc3b_word w);
    lc3b_nzp r;
    if (w[15])
      r = 3'b100;
    else if (w == 16'h0000)
      r = 3'b010;
    else
      r = 3'b001;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter, one branch-history entry.
// Resets to weakly-not-taken.
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             taken,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] INIT = WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH-1:0] MAX  = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= INIT;
    end else if (en) begin
      if (taken && count != MAX)
        count <= count + WIDTH'(1);
      else if (!taken && count != '0)
        count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/br_cc_resolver.sv
// LC-3b branch resolver: NZP register with writeback bypass,
// BHT predict/train, mispredict statistics.
module br_cc_resolver
  import lc3b_types::*;
#(
  parameter int BHT_DEPTH      = 16,
  parameter int CTR_WIDTH      = 2,
  parameter int MISS_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cc_load,
  input  lc3b_word                  cc_value,
  input  logic                      pred_req,
  input  lc3b_word                  pred_pc,
  output logic                      pred_valid,
  output logic                      pred_taken,
  input  logic                      br_valid,
  input  lc3b_word                  br_ir,
  input  lc3b_word                  br_pc,
  input  logic                      br_pred,
  output logic                      res_valid,
  output logic                      res_taken,
  output logic                      res_mispredict,
  output lc3b_nzp                   cc_nzp,
  output logic [MISS_CNT_WIDTH-1:0] miss_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [CTR_WIDTH-1:0] ctr [BHT_DEPTH];
  logic [IDX_W-1:0]     pred_idx;
  logic [IDX_W-1:0]     br_idx;
  logic [IDX_W-1:0]     train_idx;
  lc3b_nzp              nzp_eff;
  logic                 is_br;
  logic                 taken;
  logic                 unused_bits;

  assign pred_idx = pred_pc[IDX_W:1];
  assign br_idx   = br_pc[IDX_W:1];
  assign is_br    = br_valid && (br_ir[15:12] == op_br);
  assign nzp_eff  = cc_load ? nzp_of(cc_value) : cc_nzp;
  assign taken    = |(br_ir[11:9] & nzp_eff);

  assign unused_bits = ^{pred_pc[15:IDX_W+1], pred_pc[0],
                         br_pc[15:IDX_W+1], br_pc[0], br_ir[8:0]};

  // Training happens in the result cycle, so a same-cycle
  // prediction still reads the old counter value.
  for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
    sat_counter #(
      .WIDTH(CTR_WIDTH)
    ) u_ctr (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (res_valid && (train_idx == IDX_W'(g))),
      .taken  (res_taken),
      .count  (ctr[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc_nzp <= 3'b010;
    end else if (cc_load) begin
      cc_nzp <= nzp_of(cc_value);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      train_idx      <= '0;
      miss_count     <= '0;
    end else begin
      res_valid <= is_br;
      if (is_br) begin
        res_taken      <= taken;
        res_mispredict <= taken ^ br_pred;
        train_idx      <= br_idx;
        if ((taken ^ br_pred) && !(&miss_count))
          miss_count <= miss_count + MISS_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req)
        pred_taken <= ctr[pred_idx][CTR_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_br_cc_resolver.sv
// Bench for br_cc_resolver: directed plan plus random traffic
// against a cycle-level reference model.
module tb_br_cc_resolver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cc_load;
  logic [15:0] cc_value;
  logic        pred_req;
  logic [15:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        br_valid;
  logic [15:0] br_ir;
  logic [15:0] br_pc;
  logic        br_pred;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic [2:0]  cc_nzp;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [2:0] m_nzp;
  int         bht [16];
  int         m_miss;
  bit         pend_v;
  int         pend_idx;
  bit         pend_t;
  bit         e_rv, e_rt, e_rm, e_pv, e_pt;

  always #5 clk = ~clk;

  br_cc_resolver #(
    .BHT_DEPTH(16),
    .CTR_WIDTH(2),
    .MISS_CNT_WIDTH(16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cc_load       (cc_load),
    .cc_value      (cc_value),
    .pred_req      (pred_req),
    .pred_pc       (pred_pc),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .br_valid      (br_valid),
    .br_ir         (br_ir),
    .br_pc         (br_pc),
    .br_pred       (br_pred),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_mispredict(res_mispredict),
    .cc_nzp        (cc_nzp),
    .miss_count    (miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_idx(input logic [15:0] pc);
    return (int'(pc) / 2) % 16;
  endfunction

  task automatic model_reset();
    m_nzp = 3'b010;
    foreach (bht[i]) bht[i] = 1;
    m_miss = 0;
    pend_v = 0;
    pend_idx = 0;
    pend_t = 0;
    {e_rv, e_rt, e_rm, e_pv, e_pt} = '0;
  endtask

  // One clock of the reference model, using current inputs
  task automatic model_edge();
    logic [2:0] eff;
    logic [2:0] mask;
    bit tk;
    e_pv = pred_req;
    if (pred_req) e_pt = (bht[ref_idx(pred_pc)] >= 2);
    if (pend_v) begin
      if (pend_t && bht[pend_idx] < 3) bht[pend_idx]++;
      if (!pend_t && bht[pend_idx] > 0) bht[pend_idx]--;
    end
    eff = cc_load ? ref_nzp(cc_value) : m_nzp;
    mask = br_ir[11:9];
    tk = 0;
    for (int i = 0; i < 3; i++)
      if (mask[i] && eff[i]) tk = 1;
    e_rv = br_valid && (br_ir[15:12] == 4'd0);
    pend_v = e_rv;
    if (e_rv) begin
      e_rt = tk;
      e_rm = (tk != br_pred);
      if (e_rm && m_miss < 65535) m_miss++;
      pend_idx = ref_idx(br_pc);
      pend_t = tk;
    end
    if (cc_load) m_nzp = ref_nzp(cc_value);
  endtask

  task automatic check_all();
    chk("res_valid", 32'(res_valid), 32'(e_rv));
    chk("res_taken", 32'(res_taken), 32'(e_rt));
    chk("res_mispredict", 32'(res_mispredict), 32'(e_rm));
    chk("pred_valid", 32'(pred_valid), 32'(e_pv));
    chk("pred_taken", 32'(pred_taken), 32'(e_pt));
    chk("cc_nzp", 32'(cc_nzp), 32'(m_nzp));
    chk("miss_count", 32'(miss_count), 32'(m_miss));
  endtask

  task automatic drive(input bit cl, input logic [15:0] cv,
                       input bit pr, input logic [15:0] pp,
                       input bit bv, input logic [15:0] ir,
                       input logic [15:0] bp, input bit bpr);
    cc_load = cl;  cc_value = cv;
    pred_req = pr; pred_pc = pp;
    br_valid = bv; br_ir = ir; br_pc = bp; br_pred = bpr;
  endtask

  task automatic step(input bit cl, input logic [15:0] cv,
                      input bit pr, input logic [15:0] pp,
                      input bit bv, input logic [15:0] ir,
                      input logic [15:0] bp, input bit bpr);
    drive(cl, cv, pr, pp, bv, ir, bp, bpr);
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // CC derivation, one cycle after each load
    step(1, 16'h8000, 0, 0, 0, 0, 0, 0);
    chk("cc_neg", 32'(cc_nzp), 32'h4);
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0);
    chk("cc_zero", 32'(cc_nzp), 32'h2);
    step(1, 16'h0001, 0, 0, 0, 0, 0, 0);
    chk("cc_pos", 32'(cc_nzp), 32'h1);

    // Bypass: CC=010, same-cycle load of negative value, BRn
    step(1, 16'h0000, 0, 0, 0, 0, 0, 0);
    step(1, 16'hFFFF, 0, 0, 1, 16'h0800, 16'h0010, 0);
    chk("bypass_taken", 32'(res_taken), 32'h1);
    chk("bypass_miss", 32'(miss_count), 32'h1);

    // Masks and non-BR opcode
    step(0, 0, 0, 0, 1, 16'h0000, 16'h0020, 0);
    chk("mask000", 32'(res_taken), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, (k == 0) ? 16'h8000 : ((k == 1) ? 16'h0000 : 16'h0005),
           0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 16'h0E00, 16'h0022, 1);
      chk("mask111", 32'(res_taken), 32'h1);
    end
    step(0, 0, 0, 0, 1, 16'h1000, 16'h0040, 1);
    chk("add_no_res", 32'(res_valid), 32'h0);
    idle();

    // Training at 0x0040 to saturation, aliasing 0x0060
    repeat (3) step(0, 0, 0, 0, 1, 16'h0E00, 16'h0040, 0);
    idle();
    chk("bht_sat", 32'(bht[0]), 32'd3);
    step(0, 0, 1, 16'h0040, 0, 0, 0, 0);
    chk("pred_0040", 32'(pred_taken), 32'h1);
    step(0, 0, 1, 16'h0060, 0, 0, 0, 0);
    chk("pred_alias", 32'(pred_taken), 32'h1);

    // Read-before-write on index 2 (counter 01)
    step(0, 0, 0, 0, 1, 16'h0E00, 16'h0004, 0);
    step(0, 0, 1, 16'h0004, 0, 0, 0, 0);
    chk("rbw_old", 32'(pred_taken), 32'h0);
    step(0, 0, 1, 16'h0004, 0, 0, 0, 0);
    chk("rbw_new", 32'(pred_taken), 32'h1);

    // Reset mid-flight: result must never appear
    drive(0, 0, 0, 0, 1, 16'h0E00, 16'h0008, 0);
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_no_res", 32'(res_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    chk("rst_cc", 32'(cc_nzp), 32'h2);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 16'(2 * i), 0, 0, 0, 0);
      chk("rst_bht", 32'(pred_taken), 32'h0);
    end

    // Random concurrent traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ir;
      logic [15:0] cv;
      ir = 16'($urandom);
      if ($urandom_range(0, 9) < 7) ir[15:12] = 4'h0;
      cv = 16'($urandom);
      if ($urandom_range(0, 5) == 0) cv = 16'h0000;
      step(1'($urandom), cv,
           1'($urandom), 16'($urandom_range(0, 63)),
           1'($urandom_range(0, 3) != 0), ir,
           16'($urandom_range(0, 63)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
